// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler: grants one requester at a time and serializes its byte
// onto SDout as a high start bit, d0..d7 LSB first, then GAP low guard bits.
module uart_tx_sched #(
  parameter int NREQ = 4,
  parameter int GAP  = 1,
  localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int GW  = (GAP > 1) ? $clog2(GAP) : 1
) (
  input  logic              SCin,
  input  logic              RSTin,
  input  logic [NREQ-1:0]   REQ,
  input  logic [8*NREQ-1:0] PDin,
  output logic [NREQ-1:0]   GNT,
  output logic              SDout,
  output logic              Busy,
  output logic              Done,
  output logic [OW-1:0]     Owner
);

  generate
    if (NREQ < 1) begin : g_bad_nreq
      $error("uart_tx_sched: NREQ must be at least 1");
    end
    if (GAP < 1) begin : g_bad_gap
      $error("uart_tx_sched: GAP must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_START,
    S_DATA,
    S_GAP
  } state_t;

  state_t          state, next_state;
  logic [3:0]      flush_cnt, flush_cnt_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [GW-1:0]   gap_cnt, gap_cnt_n;
  logic [OW-1:0]   ptr, ptr_n;
  logic [7:0]      shreg, shreg_n;
  logic [NREQ-1:0] gnt_n;
  logic            sd_n, busy_n, done_n;
  logic [OW-1:0]   owner_n;

  logic            any_req;
  logic [OW-1:0]   cand;
  logic [OW-1:0]   win;
  logic [7:0]      win_byte;
  logic [NREQ-1:0] win_onehot;
  logic            gap_last;
  logic            arb_edge;
  logic            grant;

  // Scan from ptr+NREQ down to ptr+1 so the closest requester after ptr is written last and wins.
  always_comb begin
    any_req = 1'b0;
    cand    = '0;
    win     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = OW'((int'(ptr) + k) % NREQ);
      if (REQ[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
    win_byte   = '0;
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == OW'(i)) begin
        win_byte      = PDin[8*i +: 8];
        win_onehot[i] = 1'b1;
      end
    end
  end

  assign gap_last = (gap_cnt == GW'(GAP - 1));
  assign arb_edge = (state == S_IDLE) || ((state == S_GAP) && gap_last);
  assign grant    = arb_edge && any_req;

  always_ff @(posedge SCin) begin
    if (RSTin) begin
      state <= S_FLUSH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FLUSH: next_state = (flush_cnt == 4'd9) ? S_IDLE : S_FLUSH;
      S_IDLE:  next_state = any_req ? S_START : S_IDLE;
      S_START: next_state = S_DATA;
      S_DATA:  next_state = (bit_cnt == 3'd7) ? S_GAP : S_DATA;
      S_GAP: begin
        if (gap_last) begin
          next_state = any_req ? S_START : S_IDLE;
        end else begin
          next_state = S_GAP;
        end
      end
      default: next_state = S_FLUSH;
    endcase
  end

  // Next values for every registered output and datapath register.
  always_comb begin
    flush_cnt_n = flush_cnt;
    bit_cnt_n   = bit_cnt;
    gap_cnt_n   = gap_cnt;
    ptr_n       = ptr;
    shreg_n     = shreg;
    owner_n     = Owner;
    gnt_n       = '0;
    sd_n        = 1'b0;
    done_n      = 1'b0;
    busy_n      = (next_state == S_START) || (next_state == S_DATA) || (next_state == S_GAP);

    case (state)
      S_FLUSH: begin
        if (flush_cnt != 4'd9) begin
          flush_cnt_n = flush_cnt + 4'd1;
        end
      end
      S_START: begin
        sd_n      = shreg[0];
        shreg_n   = {1'b0, shreg[7:1]};
        bit_cnt_n = 3'd0;
      end
      S_DATA: begin
        if (bit_cnt == 3'd7) begin
          gap_cnt_n = '0;
          done_n    = 1'b1;
        end else begin
          sd_n      = shreg[0];
          shreg_n   = {1'b0, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
        end
      end
      S_GAP: begin
        if (!gap_last) begin
          gap_cnt_n = gap_cnt + GW'(1);
        end
      end
      default: ;
    endcase

    if (grant) begin
      shreg_n = win_byte;
      owner_n = win;
      ptr_n   = win;
      gnt_n   = win_onehot;
      sd_n    = 1'b1;
    end
  end

  always_ff @(posedge SCin) begin
    if (RSTin) begin
      flush_cnt <= 4'd0;
      bit_cnt   <= 3'd0;
      gap_cnt   <= '0;
      ptr       <= OW'(NREQ - 1);
      shreg     <= 8'd0;
      Owner     <= '0;
      GNT       <= '0;
      SDout     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      flush_cnt <= flush_cnt_n;
      bit_cnt   <= bit_cnt_n;
      gap_cnt   <= gap_cnt_n;
      ptr       <= ptr_n;
      shreg     <= shreg_n;
      Owner     <= owner_n;
      GNT       <= gnt_n;
      SDout     <= sd_n;
      Busy      <= busy_n;
      Done      <= done_n;
    end
  end

endmodule
